// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX/RX pair: frame constants, FSM state
// encodings and the receiver's start-bit centring helper.
package uart_pkg;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  // Cycles the receiver waits after first seeing the start bit before it
  // re-checks the line; every later sample lands at the same bit offset.
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserializer. Detects the start bit, re-checks it after the half-bit
// delay, then samples each data bit and the stop bit one bit-time apart.
// A good stop bit loads Data_out and strobes received for one cycle; a low
// stop bit drops the byte silently.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] Data_out,
  output logic                 received
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = half_bit(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] H_CNT    = CW'(H);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  rx_state_e            state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic [DATA_BITS-1:0] data_out_next;
  logic                 received_next;

  // State, counters, shift register and the registered byte/strobe outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      Data_out <= '0;
      received <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      bit_idx  <= bit_idx_next;
      shreg    <= shreg_next;
      Data_out <= data_out_next;
      received <= received_next;
    end
  end

  // Next-state logic. When H is zero the sample that detects the start bit
  // is already the centre check, so the receiver goes straight to DATA.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    bit_idx_next  = bit_idx;
    shreg_next    = shreg;
    data_out_next = Data_out;
    received_next = 1'b0;
    case (state)
      RX_IDLE: begin
        if (rx == START_BIT) begin
          if (H == 0) begin
            cnt_next     = '0;
            bit_idx_next = '0;
            state_next   = RX_DATA;
          end else begin
            cnt_next   = CW'(1);
            state_next = RX_START;
          end
        end
      end
      RX_START: begin
        if (cnt == H_CNT) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = (rx == START_BIT) ? RX_DATA : RX_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      RX_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          shreg_next = {rx, shreg[DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) begin
            state_next = RX_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      RX_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          if (rx == STOP_BIT) begin
            data_out_next = shreg;
            received_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serializer. While send is high it frames Data_in (latched at frame
// start) and shifts it out LSB first; back-to-back frames are separated by a
// single idle-high cycle. The line output is registered.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] Data_in,
  output logic                 tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

  tx_state_e            state, state_next;
  logic [CW-1:0]        cnt, cnt_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 line_next;

  // State, counters, latched byte and the registered serial line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= TX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= STOP_BIT;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_idx_next;
      shreg   <= shreg_next;
      tx      <= line_next;
    end
  end

  // Next-state logic; line_next is the level the current state puts on the
  // wire, so each phase appears on tx one cycle after the state is entered.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shreg_next   = shreg;
    line_next    = STOP_BIT;
    case (state)
      TX_IDLE: begin
        line_next = STOP_BIT;
        if (send) begin
          shreg_next = Data_in;
          cnt_next   = '0;
          state_next = TX_START;
        end
      end
      TX_START: begin
        line_next = START_BIT;
        if (cnt == CNT_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = TX_DATA;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      TX_DATA: begin
        line_next = shreg[bit_idx];
        if (cnt == CNT_LAST) begin
          cnt_next = '0;
          if (bit_idx == BIT_LAST) begin
            state_next = TX_STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      TX_STOP: begin
        line_next = STOP_BIT;
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = TX_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/uart_loopback_tb.sv
// UART loopback: transmitter wired to receiver through an internal line.
// Interface protocol: send is a level enable, not a valid/ready pair -- while
// it is high frames follow each other with one idle cycle between them, and
// received is a single-cycle strobe that qualifies a freshly loaded Data_out.
module uart_loopback_tb #(
  parameter int CLKS_PER_BIT = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       send,
  input  logic [7:0] Data_in,
  output logic [7:0] Data_out,
  output logic       received
);

  logic serial_line;

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clock   (clock),
    .reset_n (reset_n),
    .send    (send),
    .Data_in (Data_in),
    .tx      (serial_line)
  );

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (serial_line),
    .Data_out (Data_out),
    .received (received)
  );

endmodule

// File: tb/tb_uart_loopback_tb.sv
// Bench for uart_loopback_tb: three instances (2, 5 and 16 clocks per bit)
// on one 10 ns clock. A frame-level model predicts, for every frame start,
// the byte and the cycle of its received pulse.
module tb_uart_loopback_tb;

  localparam int NDUT = 3;

  // Clock / reset block
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  logic [NDUT-1:0] rst_v;
  logic [NDUT-1:0] send_v;
  logic [NDUT-1:0] recv_v;
  logic [7:0]      din_v  [NDUT];
  logic [7:0]      dout_v [NDUT];

  uart_loopback_tb #(.CLKS_PER_BIT(2)) u_dut0 (
    .clock(clock), .reset_n(rst_v[0]), .send(send_v[0]), .Data_in(din_v[0]),
    .Data_out(dout_v[0]), .received(recv_v[0]));
  uart_loopback_tb #(.CLKS_PER_BIT(5)) u_dut1 (
    .clock(clock), .reset_n(rst_v[1]), .send(send_v[1]), .Data_in(din_v[1]),
    .Data_out(dout_v[1]), .received(recv_v[1]));
  uart_loopback_tb #(.CLKS_PER_BIT(16)) u_dut2 (
    .clock(clock), .reset_n(rst_v[2]), .send(send_v[2]), .Data_in(din_v[2]),
    .Data_out(dout_v[2]), .received(recv_v[2]));

  // Scoreboard
  logic [7:0] exp_q [NDUT][$];
  int         exp_t [NDUT][$];
  int         next_free [NDUT];
  logic [7:0] last_byte [NDUT];
  logic       prev_recv [NDUT];
  int         pulses    [NDUT];
  int         last_pulse_cyc [NDUT];
  int         checks   = 0;
  int         failures = 0;

  function automatic int cpb(input int d);
    case (d)
      0:       return 2;
      1:       return 5;
      default: return 16;
    endcase
  endfunction

  // Frame model: a frame starts on any edge with reset released and send
  // high once the previous frame period (10*C+1) has elapsed; its byte is
  // Data_in at that edge and its pulse follows H+9*C+2 edges later.
  task automatic model_edge();
    for (int d = 0; d < NDUT; d++) begin
      int e;
      e = cyc + 1;
      if (rst_v[d] === 1'b1 && send_v[d] === 1'b1 && e >= next_free[d]) begin
        exp_q[d].push_back(din_v[d]);
        exp_t[d].push_back(e + (cpb(d) - 1) / 2 + 9 * cpb(d) + 2);
        next_free[d] = e + 10 * cpb(d) + 1;
      end
    end
  endtask

  task automatic monitor();
    for (int d = 0; d < NDUT; d++) begin
      while (exp_t[d].size() > 0 && exp_t[d][0] < cyc) begin
        checks++; failures++;
        $display("FAIL missed_pulse dut%0d cycle %0d: no pulse, required byte %02h at cycle %0d",
                 d, cyc, exp_q[d][0], exp_t[d][0]);
        void'(exp_t[d].pop_front());
        void'(exp_q[d].pop_front());
      end
      if (recv_v[d] === 1'b1) begin
        pulses[d]++;
        last_pulse_cyc[d] = cyc;
        checks++;
        if (prev_recv[d] === 1'b1) begin
          failures++;
          $display("FAIL pulse_width dut%0d cycle %0d: received high 2 cycles, required 1", d, cyc);
        end
        checks++;
        if (exp_t[d].size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse dut%0d cycle %0d: got pulse with %02h, required none",
                   d, cyc, dout_v[d]);
        end else begin
          int t;
          t = exp_t[d].pop_front();
          last_byte[d] = exp_q[d].pop_front();
          checks++;
          if (t != cyc) begin
            failures++;
            $display("FAIL pulse_time dut%0d: got cycle %0d, required cycle %0d", d, cyc, t);
          end
        end
      end else if (recv_v[d] !== 1'b0) begin
        checks++; failures++;
        $display("FAIL received_known dut%0d cycle %0d: got %b, required 0/1", d, cyc, recv_v[d]);
      end
      checks++;
      if (dout_v[d] !== last_byte[d]) begin
        failures++;
        $display("FAIL data_out dut%0d cycle %0d: got %02h, required %02h",
                 d, cyc, dout_v[d], last_byte[d]);
      end
      prev_recv[d] = recv_v[d];
    end
  endtask

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      model_edge();
      @(posedge clock);
      #1;
      monitor();
    end
  endtask

  task automatic do_reset(input int d);
    rst_v[d] = 1'b0;
    exp_q[d].delete();
    exp_t[d].delete();
    next_free[d] = 0;
    last_byte[d] = 8'h00;
    prev_recv[d] = 1'b0;
  endtask

  function automatic bit pending();
    for (int d = 0; d < NDUT; d++) if (exp_t[d].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (pending() && n < budget) begin
      tick(1);
      n++;
    end
    if (pending()) begin
      checks++; failures++;
      $display("FAIL drain_timeout cycle %0d: pulses still outstanding after %0d cycles", cyc, budget);
      for (int d = 0; d < NDUT; d++) begin
        exp_q[d].delete();
        exp_t[d].delete();
      end
    end
  endtask

  task automatic check_idle_in_reset(input string name);
    for (int d = 0; d < NDUT; d++) begin
      if (rst_v[d] === 1'b0) begin
        checks++;
        if (recv_v[d] !== 1'b0 || dout_v[d] !== 8'h00) begin
          failures++;
          $display("FAIL %s dut%0d: got received=%b Data_out=%02h, required 0/00",
                   name, d, recv_v[d], dout_v[d]);
        end
      end
    end
    checks++;
    if (rst_v[0] === 1'b0 && u_dut0.serial_line !== 1'b1) begin
      failures++;
      $display("FAIL %s_line: got %b, required 1", name, u_dut0.serial_line);
    end
  endtask

  // Scenarios
  task automatic test_reset();
    int rel;
    send_v = 3'b001;
    for (int d = 0; d < NDUT; d++) begin
      din_v[d] = 8'h3C;
      pulses[d] = 0;
      last_pulse_cyc[d] = -1;
      do_reset(d);
    end
    tick(4);
    check_idle_in_reset("reset_state");
    rst_v = '1;
    rel = cyc;
    for (int i = 0; i < 40 && pulses[0] == 0; i++) tick(1);
    checks++;
    if (last_pulse_cyc[0] != rel + 21) begin
      failures++;
      $display("FAIL first_pulse_after_reset: got cycle %0d, required %0d", last_pulse_cyc[0], rel + 21);
    end
    send_v[0] = 1'b0;
    drain(60);
    tick(30);
  endtask

  task automatic test_single_byte();
    int p0;
    p0 = pulses[0];
    din_v[0] = 8'hCB;
    send_v[0] = 1'b1;
    tick(1);
    send_v[0] = 1'b0;
    tick(60);
    checks++;
    if (pulses[0] - p0 != 1) begin
      failures++;
      $display("FAIL single_byte_count: got %0d pulses, required 1", pulses[0] - p0);
    end
    checks++;
    if (dout_v[0] !== 8'hCB) begin
      failures++;
      $display("FAIL single_byte_data: got %02h, required cb", dout_v[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] steps [4];
    steps = '{8'h00, 8'hCB, 8'h93, 8'h68};
    din_v[0] = steps[0];
    send_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_v[0] = steps[i];
      tick(i == 3 ? 100 : 24);
    end
    send_v[0] = 1'b0;
    drain(60);
    tick(30);
    checks++;
    if (dout_v[0] !== 8'h68) begin
      failures++;
      $display("FAIL back_to_back_final: got %02h, required 68", dout_v[0]);
    end
  endtask

  task automatic test_mid_frame_data();
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 255));
    b = a ^ 8'($urandom_range(1, 255));
    din_v[0] = a;
    send_v[0] = 1'b1;
    tick(6);
    din_v[0] = b;
    tick(40);
    send_v[0] = 1'b0;
    drain(60);
    tick(30);
    checks++;
    if (dout_v[0] !== b) begin
      failures++;
      $display("FAIL mid_frame_data_next: got %02h, required %02h", dout_v[0], b);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] x, y;
    x = 8'($urandom_range(1, 255));
    y = 8'($urandom_range(1, 255));
    din_v[0] = x;
    send_v[0] = 1'b1;
    tick(25);
    checks++;
    if (dout_v[0] !== x) begin
      failures++;
      $display("FAIL pre_reset_data: got %02h, required %02h", dout_v[0], x);
    end
    do_reset(0);
    #1;
    check_idle_in_reset("mid_frame_reset");
    tick(3);
    check_idle_in_reset("mid_frame_reset_hold");
    rst_v[0] = 1'b1;
    din_v[0] = y;
    tick(45);
    send_v[0] = 1'b0;
    drain(60);
    tick(30);
    checks++;
    if (dout_v[0] !== y) begin
      failures++;
      $display("FAIL post_reset_data: got %02h, required %02h", dout_v[0], y);
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] bytes_v [3];
    int p2;
    bytes_v = '{8'hA5, 8'h00, 8'hFF};
    p2 = pulses[2];
    send_v[1] = 1'b1;
    send_v[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din_v[1] = bytes_v[i];
      din_v[2] = bytes_v[i];
      tick(161);
    end
    send_v[1] = 1'b0;
    send_v[2] = 1'b0;
    drain(200);
    tick(60);
    checks++;
    if (pulses[2] - p2 != 3) begin
      failures++;
      $display("FAIL sweep_cpb16_count: got %0d pulses, required 3", pulses[2] - p2);
    end
    checks++;
    if (dout_v[1] !== 8'hFF || dout_v[2] !== 8'hFF) begin
      failures++;
      $display("FAIL sweep_final: got %02h/%02h, required ff/ff", dout_v[1], dout_v[2]);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 700; i++) begin
      for (int d = 0; d < NDUT; d++) begin
        if ($urandom_range(0, 39) == 0) send_v[d] = ~send_v[d];
        if ($urandom_range(0, 7) == 0) din_v[d] = 8'($urandom_range(0, 255));
        if (rst_v[d] === 1'b0) begin
          if ($urandom_range(0, 1) == 0) rst_v[d] = 1'b1;
        end else if ($urandom_range(0, 299) == 0) begin
          do_reset(d);
        end
      end
      tick(1);
    end
    send_v = '0;
    rst_v = '1;
    drain(200);
    tick(60);
  endtask

  // Main sequence and final report
  initial begin
    rst_v  = '0;
    send_v = '0;
    for (int d = 0; d < NDUT; d++) din_v[d] = 8'h00;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_mid_frame_data();
    test_mid_frame_reset();
    test_param_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule
